demux_121_124_181: RTL and testbench
====================================

DEMUX_121_124_181 -- requirements
Module: demux_121_124_181

Interface
REQ-001 The block SHALL have no parameters; all widths SHALL be fixed as listed below.
REQ-002 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-003 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 inData121  input  1  channel A data (1-bit, 1:2).
REQ-006 inSel121  input  1  channel A select.
REQ-007 inEn121  input  1  channel A load enable.
REQ-008 outData121  output  2  channel A registered outputs.
REQ-009 inData124  input  4  channel B data (4-bit nibble, 1:4).
REQ-010 inSel124  input  2  channel B select; a 1-bit driver zero-extends, reaching slots 0/1 only.
REQ-011 inEn124  input  1  channel B load enable.
REQ-012 outData124  output  16  channel B registered outputs; slot k = bits [4k+3:4k].
REQ-013 inData181  input  1  channel C data (1-bit, 1:8).
REQ-014 inSel181  input  3  channel C select.
REQ-015 inEn181  input  1  channel C load enable.
REQ-016 outData181  output  8  channel C registered outputs.

Function
REQ-017 Each channel SHALL be independent; no channel SHALL affect another.
REQ-018 With enable high at a rising edge, the output register SHALL load the data into the selected slot and zeros into all other slots.
REQ-019 Channel A SHALL set outData121[inSel121] = inData121.
REQ-020 Channel B SHALL set slot inSel124 of outData124 = inData124.
REQ-021 Channel C SHALL set outData181[inSel181] = inData181.
REQ-022 With enable low, the output register SHALL hold its previous value.
REQ-023 Latency SHALL be exactly one clock from sampled inputs to visible outputs.
REQ-024 No combinational path SHALL exist from any input to any output.
REQ-025 Every select value SHALL be legal because select widths exactly cover the slot counts.
REQ-026 When selected data is zero, the whole output of that channel SHALL be zero, which is indistinguishable from idle by design.
REQ-027 Select or data changes between edges SHALL have no effect; only values present at the rising edge SHALL matter.

Reset
REQ-028 While rst is high at a rising edge, outData121, outData124 and outData181 SHALL all become 0.
REQ-029 rst SHALL take priority over enable.
REQ-030 Outputs SHALL stay 0 on every edge for as long as rst is held, and enables asserted during reset SHALL be ignored.
REQ-031 On the first edge after rst deasserts with enable high, the register SHALL load normally with no extra delay cycle.

Structure
REQ-032 Package demux_pkg SHALL hold the constants W121=1/N121=2, W124=4/N124=4 and W181=1/N181=8, plus the select widths derived with $clog2.
REQ-033 One generic sub-module demux_1ton SHALL be used, parameterised by data width and slot count, with a registered output, enable and synchronous reset.
REQ-034 The top level SHALL instantiate demux_1ton three times.

Verification
REQ-035 rst=1 for 2 clocks while all enables=1 with nonzero data -> all outputs 0 during reset.
REQ-036 Channel C: inEn181=1, inData181=1, sweep inSel181 0..7 -> outData181 = 8'h01,02,04,...,80, each one clock after its select.
REQ-037 Channel B: inEn124=1, inData124=4'hA, inSel124=2 -> outData124=16'h0A00; then inSel124=3, inData124=4'h5 -> 16'h5000.
REQ-038 Channel A: inSel121=1, inData121=1, inEn121=1 -> outData121=2'b10; then inEn121=0 with inSel121=0 -> output holds 2'b10.
REQ-039 Simultaneous events: all three channels loaded on the same edge -> each result matches REQ-019 to REQ-021 independently.
REQ-040 Mid-operation reset: outputs nonzero, then rst=1 for 1 clock with enable=1 -> outputs 0 after that edge; after rst drops, the next edge loads normally.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared widths and slot counts for the three demultiplexer channels.
package demux_pkg;
  localparam int W121 = 1;
  localparam int N121 = 2;
  localparam int S121 = $clog2(N121);
  localparam int W124 = 4;
  localparam int N124 = 4;
  localparam int S124 = $clog2(N124);
  localparam int W181 = 1;
  localparam int N181 = 8;
  localparam int S181 = $clog2(N181);
endpackage

// File: rtl/demux_121_124_181_1ton.sv
// Generic registered 1:N demultiplexer: on enable, the selected slot takes the
// data and every other slot is cleared; otherwise the register holds.
module demux_1ton #(
  parameter int DATA_W = 1,
  parameter int SLOTS  = 2,
  parameter int SEL_W  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         data_i,
  input  logic [SEL_W-1:0]          sel_i,
  input  logic                      en_i,
  output logic [DATA_W*SLOTS-1:0]   data_o
);
  logic [DATA_W*SLOTS-1:0] out_d, out_q;

  always_comb begin
    out_d = out_q;
    if (en_i) begin
      out_d = '0;
      for (int k = 0; k < SLOTS; k++) begin
        if (sel_i == SEL_W'(k)) out_d[k*DATA_W +: DATA_W] = data_i;
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign data_o = out_q;
endmodule

// File: rtl/demux_121_124_181.sv
// Three independent registered demultiplexer channels (1:2 bit, 1:4 nibble, 1:8 bit).
module demux_121_124_181
  import demux_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W121-1:0]      inData121,
  input  logic [S121-1:0]      inSel121,
  input  logic                 inEn121,
  output logic [W121*N121-1:0] outData121,
  input  logic [W124-1:0]      inData124,
  input  logic [S124-1:0]      inSel124,
  input  logic                 inEn124,
  output logic [W124*N124-1:0] outData124,
  input  logic [W181-1:0]      inData181,
  input  logic [S181-1:0]      inSel181,
  input  logic                 inEn181,
  output logic [W181*N181-1:0] outData181
);
  demux_1ton #(.DATA_W(W121), .SLOTS(N121), .SEL_W(S121)) u_ch121 (
    .clk(clk), .rst(rst), .data_i(inData121), .sel_i(inSel121),
    .en_i(inEn121), .data_o(outData121)
  );

  demux_1ton #(.DATA_W(W124), .SLOTS(N124), .SEL_W(S124)) u_ch124 (
    .clk(clk), .rst(rst), .data_i(inData124), .sel_i(inSel124),
    .en_i(inEn124), .data_o(outData124)
  );

  demux_1ton #(.DATA_W(W181), .SLOTS(N181), .SEL_W(S181)) u_ch181 (
    .clk(clk), .rst(rst), .data_i(inData181), .sel_i(inSel181),
    .en_i(inEn181), .data_o(outData181)
  );
endmodule

// File: tb/tb_demux_121_124_181.sv
// Randomized and directed bench with a shift-based reference model per channel.
module tb_demux_121_124_181;
  logic        clk = 1'b0;
  logic        rst;
  logic        inData121, inSel121, inEn121;
  logic [1:0]  outData121;
  logic [3:0]  inData124;
  logic [1:0]  inSel124;
  logic        inEn124;
  logic [15:0] outData124;
  logic        inData181;
  logic [2:0]  inSel181;
  logic        inEn181;
  logic [7:0]  outData181;

  int total = 0;
  int bad   = 0;
  logic [1:0]  exp121 = '0;
  logic [15:0] exp124 = '0;
  logic [7:0]  exp181 = '0;

  always #5 clk = ~clk;

  demux_121_124_181 dut (
    .clk(clk), .rst(rst),
    .inData121(inData121), .inSel121(inSel121), .inEn121(inEn121), .outData121(outData121),
    .inData124(inData124), .inSel124(inSel124), .inEn124(inEn124), .outData124(outData124),
    .inData181(inData181), .inSel181(inSel181), .inEn181(inEn181), .outData181(outData181)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // One cycle: junk early in the low phase, real values before the edge,
  // model update at the edge, compare 1ns after it.
  task automatic step(input logic r,
                      input logic a_d, input logic a_s, input logic a_e,
                      input logic [3:0] b_d, input logic [1:0] b_s, input logic b_e,
                      input logic c_d, input logic [2:0] c_s, input logic c_e);
    @(negedge clk);
    rst = 1'b0;
    inData121 = 1'($urandom); inSel121 = 1'($urandom); inEn121 = 1'b1;
    inData124 = 4'($urandom); inSel124 = 2'($urandom); inEn124 = 1'b1;
    inData181 = 1'($urandom); inSel181 = 3'($urandom); inEn181 = 1'b1;
    #2;
    rst = r;
    inData121 = a_d; inSel121 = a_s; inEn121 = a_e;
    inData124 = b_d; inSel124 = b_s; inEn124 = b_e;
    inData181 = c_d; inSel181 = c_s; inEn181 = c_e;
    @(posedge clk);
    if (r) begin
      exp121 = '0; exp124 = '0; exp181 = '0;
    end else begin
      if (a_e) exp121 = 2'(a_d) << a_s;
      if (b_e) exp124 = 16'(b_d) << (4 * b_s);
      if (c_e) exp181 = 8'(c_d) << c_s;
    end
    #1;
    chk("ch121", 16'(outData121), 16'(exp121));
    chk("ch124", outData124, exp124);
    chk("ch181", 16'(outData181), 16'(exp181));
  endtask

  initial begin
    rst = 1'b1;
    inData121 = 0; inSel121 = 0; inEn121 = 0;
    inData124 = 0; inSel124 = 0; inEn124 = 0;
    inData181 = 0; inSel181 = 0; inEn181 = 0;

    // Reset held two clocks with all enables and nonzero data
    step(1, 1, 1, 1, 4'hF, 2'd3, 1, 1, 3'd7, 1);
    step(1, 1, 0, 1, 4'h9, 2'd1, 1, 1, 3'd2, 1);
    chk("rst_all_zero", {outData124[7:0], outData181}, 16'h0000);

    // Channel C select sweep
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 4'h0, 2'd0, 0, 1, 3'(i), 1);
      chk("sweep181", 16'(outData181), 16'(8'h01 << i));
    end

    // Channel B nibble placement
    step(0, 0, 0, 0, 4'hA, 2'd2, 1, 0, 3'd0, 0);
    chk("b_0a00", outData124, 16'h0A00);
    step(0, 0, 0, 0, 4'h5, 2'd3, 1, 0, 3'd0, 0);
    chk("b_5000", outData124, 16'h5000);

    // Channel A load then hold
    step(0, 1, 1, 1, 4'h0, 2'd0, 0, 0, 3'd0, 0);
    chk("a_load", 16'(outData121), 16'h0002);
    step(0, 1, 0, 0, 4'h0, 2'd0, 0, 0, 3'd0, 0);
    chk("a_hold", 16'(outData121), 16'h0002);

    // All three channels on the same edge
    step(0, 1, 0, 1, 4'h7, 2'd1, 1, 1, 3'd5, 1);
    chk("sim_a", 16'(outData121), 16'h0001);
    chk("sim_b", outData124, 16'h0070);
    chk("sim_c", 16'(outData181), 16'h0020);

    // Zero data clears the whole channel
    step(0, 0, 1, 1, 4'h0, 2'd2, 1, 0, 3'd3, 1);
    chk("zero_b", outData124, 16'h0000);

    // Mid-operation reset, then immediate reload
    step(0, 1, 1, 1, 4'hC, 2'd0, 1, 1, 3'd6, 1);
    step(1, 1, 1, 1, 4'hC, 2'd0, 1, 1, 3'd6, 1);
    chk("midrst", {outData124[7:0], outData181}, 16'h0000);
    step(0, 1, 1, 1, 4'h3, 2'd1, 1, 1, 3'd4, 1);
    chk("post_rst_b", outData124, 16'h0030);
    chk("post_rst_c", 16'(outData181), 16'h0010);

    // Random traffic with occasional reset
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 19) == 0),
           1'($urandom), 1'($urandom), 1'($urandom),
           4'($urandom), 2'($urandom), 1'($urandom),
           1'($urandom), 3'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
